// File: rtl/verificador_tabla.sv
// rtl/verificador_tabla.sv - truth-table sweeper and equivalence checker with MISR signature
// Drives every N_IN-bit vector, compares reference/simplified output pairs, signs the responses.
module verificador_tabla #(
  parameter int N_IN    = 5,
  parameter int N_PAIRS = 4,
  parameter int SETTLE  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic [N_IN-1:0]      vec,
  input  logic [2*N_PAIRS-1:0] resp,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [N_PAIRS-1:0]   err_mask,
  output logic [N_IN:0]        err_count,
  output logic [N_IN-1:0]      first_err_vec,
  output logic                 first_err_valid,
  output logic [15:0]          signature
);

  typedef enum logic [1:0] {IDLE, HOLD, FIN} state_t;

  state_t               state_q, state_d;
  logic [N_IN-1:0]      vec_q, vec_d;
  logic [3:0]           hold_q, hold_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 pass_q, pass_d;
  logic [N_PAIRS-1:0]   mask_q, mask_d;
  logic [N_IN:0]        cnt_q, cnt_d;
  logic [N_IN-1:0]      fev_q, fev_d;
  logic                 fevalid_q, fevalid_d;
  logic [15:0]          sig_q, sig_d;

  logic [N_PAIRS-1:0]   mismatch;
  logic [15:0]          resp_ext;
  logic                 feedback;
  logic                 last_vec;
  logic                 sample;

  always_comb begin
    mismatch = '0;
    for (int k = 0; k < N_PAIRS; k++) begin
      mismatch[k] = resp[2*k+1] ^ resp[2*k];
    end
  end

  assign resp_ext = 16'(resp);
  assign feedback = sig_q[15] ^ sig_q[14] ^ sig_q[12] ^ sig_q[3];
  assign last_vec = (vec_q == {N_IN{1'b1}});
  assign sample   = (hold_q == 4'(SETTLE));

  always_comb begin
    state_d   = state_q;
    vec_d     = vec_q;
    hold_d    = hold_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    pass_d    = pass_q;
    mask_d    = mask_q;
    cnt_d     = cnt_q;
    fev_d     = fev_q;
    fevalid_d = fevalid_q;
    sig_d     = sig_q;
    case (state_q)
      IDLE, FIN: begin
        if (start) begin
          state_d   = HOLD;
          vec_d     = '0;
          hold_d    = '0;
          busy_d    = 1'b1;
          pass_d    = 1'b0;
          mask_d    = '0;
          cnt_d     = '0;
          fev_d     = '0;
          fevalid_d = 1'b0;
          sig_d     = 16'hFFFF;
        end else if (state_q == FIN) begin
          state_d = IDLE;
        end
      end
      HOLD: begin
        if (sample) begin
          hold_d = '0;
          mask_d = mask_q | mismatch;
          sig_d  = {sig_q[14:0], feedback} ^ resp_ext;
          if (|mismatch) begin
            cnt_d = cnt_q + (N_IN+1)'(1);
            if (!fevalid_q) begin
              fev_d     = vec_q;
              fevalid_d = 1'b1;
            end
          end
          // The final vector stays on vec; results freeze as done pulses.
          if (last_vec) begin
            state_d = FIN;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (cnt_d == '0);
          end else begin
            vec_d = vec_q + N_IN'(1);
          end
        end else begin
          hold_d = hold_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      vec_q     <= '0;
      hold_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      mask_q    <= '0;
      cnt_q     <= '0;
      fev_q     <= '0;
      fevalid_q <= 1'b0;
      sig_q     <= '0;
    end else begin
      state_q   <= state_d;
      vec_q     <= vec_d;
      hold_q    <= hold_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      mask_q    <= mask_d;
      cnt_q     <= cnt_d;
      fev_q     <= fev_d;
      fevalid_q <= fevalid_d;
      sig_q     <= sig_d;
    end
  end

  assign vec             = vec_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign err_mask        = mask_q;
  assign err_count       = cnt_q;
  assign first_err_vec   = fev_q;
  assign first_err_valid = fevalid_q;
  assign signature       = sig_q;

endmodule
